pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: MD_TIMEOUT, 64, max MD_WAIT cycles before abort (range 2..255).
REQ-002 Ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rs1_D, rs2_D  in  5 each  decode-stage source registers.
- rs1_E, rs2_E  in  5 each  execute-stage source registers.
- rd_E  in  5  execute-stage destination.
- MemRead_E, RegWrite_E  in  1 each  execute-stage controls.
- rd_M, RegWrite_M  in  5, 1  memory-stage writer.
- rd_W, RegWrite_W  in  5, 1  writeback-stage writer.
- branch_taken_E  in  1  PC redirect resolved in EX.
- md_req_E  in  1  EX holds a multi-cycle mul/div op.
- md_done  in  1  mul/div unit result valid.
- md_start  out  1  one-cycle mul/div launch pulse.
- StallF, StallD, StallE  out  1 each  hold PC, IF/ID, ID/EX.
- FlushD, FlushE  out  1 each  bubble IF/ID, ID/EX.
- ForwardAE, ForwardBE  out  2 each  EX operand select.
- md_timeout_err  out  1  sticky timeout flag.

Function
REQ-003 FSM states: RUN, MD_WAIT; encoding lives in the shared package.
REQ-004 Forwarding, combinational: 2'b10 if RegWrite_M, rd_M!=0, rd_M==rsX_E; else 2'b01 if RegWrite_W, rd_W!=0, rd_W==rsX_E; else 2'b00. M beats W.
REQ-005 Load-use, RUN only: MemRead_E, rd_E!=0, rd_E matching rs1_D or rs2_D -> StallF=StallD=FlushE=1 in that cycle; no state change.
REQ-006 Branch, RUN only: branch_taken_E -> FlushD=FlushE=1, StallF=StallD=0; overrides load-use and md_req_E in the same cycle.
REQ-007 RUN with md_req_E and no branch -> md_start=1 for exactly that cycle; StallF=StallD=StallE=1; next state MD_WAIT; cycle counter cleared to 0.
REQ-008 MD_WAIT: StallF=StallD=StallE=1, md_start=0, counter increments each cycle; load-use and branch logic ignored.
REQ-009 MD_WAIT with md_done=1 -> all stalls 0 that cycle; next state RUN.
REQ-010 MD_WAIT with counter==MD_TIMEOUT-1 and md_done=0 -> md_timeout_err set; stalls released; FlushE=1; next state RUN.
REQ-011 md_done in RUN is ignored.
REQ-012 md_timeout_err remains set until reset.
REQ-013 A new md_req_E on the first RUN cycle after MD_WAIT is not relaunched. Block-internal md_issued flag clears when md_req_E falls or FlushE asserts.

Reset
REQ-014 reset_n=0 asynchronously: state=RUN, counter=0, md_issued=0, md_timeout_err=0, md_start=0.
REQ-015 Reset mid-MD_WAIT aborts the op without setting md_timeout_err.
REQ-016 After release, the first rising edge evaluates normally.

Configuration
REQ-017 Macro HAZARD_PERF_CNT_EN defined: adds outputs stall_cycles[31:0] and flush_count[31:0].
- stall_cycles increments on any cycle with StallD=1.
- flush_count increments on any cycle with FlushE=1.
- Both saturate at 32'hFFFF_FFFF and reset to 0.
REQ-018 Macro undefined: those ports and counters are absent; remaining behaviour is identical.

Structure
REQ-019 Package pipe_ctrl_pkg holds:
- FSM state typedef.
- Forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
REQ-020 Forwarding logic is sub-module forward_unit, instantiated twice (A, B).

Verification
REQ-021 Forwarding: rd_M=5, RegWrite_M=1, rd_W=5, RegWrite_W=1, rs1_E=5 -> ForwardAE=2'b10; same with rd_M=0 -> ForwardAE=2'b01.
REQ-022 Load-use: MemRead_E=1, rd_E=7, rs2_D=7 -> StallF=StallD=FlushE=1 for one cycle; with branch_taken_E=1 also -> FlushD=FlushE=1, StallD=0.
REQ-023 Mul/div: md_req_E held, md_done pulsed on wait cycle 5 -> single md_start pulse; StallE=1 for 6 cycles; no second md_start.
REQ-024 Timeout: MD_TIMEOUT=8, md_done never -> md_timeout_err=1 after 8 stalled cycles; FlushE=1; state RUN.
REQ-025 Reset: reset_n low during MD_WAIT cycle 3 -> all stalls 0 immediately; md_timeout_err=0.
REQ-026 HAZARD_PERF_CNT_EN: 3 load-use events plus a 4-cycle mul/div -> stall_cycles=7, flush_count=3.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - hz_state_e : hazard FSM state (RUN / MD_WAIT)
//   - FWD_*      : EX operand forward-select codes
//   - CNT_W      : width of the mul/div wait-cycle counter
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // MD_TIMEOUT is limited to 255, so 8 bits cover every wait count.
    localparam int CNT_W = 8;

endpackage

// File: rtl/forward_unit.sv
// -----------------------------------------------------------------------------
// forward_unit
// Selects the source of one EX-stage operand. The memory-stage writer has
// priority over the writeback-stage writer because it holds the younger value.
// Writes to x0 are never forwarded.
// Ports:
//   rs_E_i        EX-stage source register
//   rd_M_i        MEM-stage destination,  RegWrite_M_i its write enable
//   rd_W_i        WB-stage destination,   RegWrite_W_i its write enable
//   fwd_o         FWD_MEM / FWD_WB / FWD_RF
// -----------------------------------------------------------------------------
module forward_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs_E_i,
    input  logic [4:0] rd_M_i,
    input  logic       RegWrite_M_i,
    input  logic [4:0] rd_W_i,
    input  logic       RegWrite_W_i,
    output logic [1:0] fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (RegWrite_M_i && (rd_M_i != 5'd0) && (rd_M_i == rs_E_i)) begin
            fwd_o = FWD_MEM;
        end else if (RegWrite_W_i && (rd_W_i != 5'd0) && (rd_W_i == rs_E_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard controller for a 5-stage pipeline: operand forwarding, load-use
// stalls, taken-branch flushes and a multi-cycle mul/div handshake with a
// timeout abort.
// Parameter:
//   MD_TIMEOUT       maximum MD_WAIT cycles before the op is aborted (2..255)
// Ports:
//   clk, reset_n     clock (rising edge), asynchronous active-low reset
//   rs1_D, rs2_D     decode-stage sources
//   rs1_E, rs2_E     execute-stage sources; rd_E, MemRead_E, RegWrite_E
//   rd_M/RegWrite_M  memory-stage writer; rd_W/RegWrite_W writeback writer
//   branch_taken_E   PC redirect resolved in EX
//   md_req_E/md_done mul/div request from EX / result valid from the unit
//   md_start         one-cycle mul/div launch pulse
//   StallF/D/E       hold PC, IF/ID, ID/EX;  FlushD/E bubble IF/ID, ID/EX
//   ForwardAE/BE     EX operand select;  md_timeout_err sticky timeout flag
// Optional build macro HAZARD_PERF_CNT_EN adds saturating 32-bit outputs
//   stall_cycles (cycles with StallD) and flush_count (cycles with FlushE).
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] rs1_D,
    input  logic [4:0] rs2_D,
    input  logic [4:0] rs1_E,
    input  logic [4:0] rs2_E,
    input  logic [4:0] rd_E,
    input  logic       MemRead_E,
    input  logic       RegWrite_E,
    input  logic [4:0] rd_M,
    input  logic       RegWrite_M,
    input  logic [4:0] rd_W,
    input  logic       RegWrite_W,
    input  logic       branch_taken_E,
    input  logic       md_req_E,
    input  logic       md_done,
    output logic       md_start,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       md_timeout_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_issued_q, md_issued_d;
    logic             err_q, err_d;
    logic             load_use;

    // RegWrite_E does not affect hazard detection; it is part of the EX
    // control bundle only for interface completeness.
    logic             unused_regwrite_e;
    assign unused_regwrite_e = RegWrite_E;

    forward_unit u_fwd_a (
        .rs_E_i       (rs1_E),
        .rd_M_i       (rd_M),
        .RegWrite_M_i (RegWrite_M),
        .rd_W_i       (rd_W),
        .RegWrite_W_i (RegWrite_W),
        .fwd_o        (ForwardAE)
    );

    forward_unit u_fwd_b (
        .rs_E_i       (rs2_E),
        .rd_M_i       (rd_M),
        .RegWrite_M_i (RegWrite_M),
        .rd_W_i       (rd_W),
        .RegWrite_W_i (RegWrite_W),
        .fwd_o        (ForwardBE)
    );

    assign load_use = MemRead_E && (rd_E != 5'd0) &&
                      ((rd_E == rs1_D) || (rd_E == rs2_D));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        md_start = 1'b0;
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;

        case (state_q)
            ST_RUN: begin
                // Branch wins over everything; an md op already launched for
                // the current EX instruction is not launched again.
                if (branch_taken_E) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (md_req_E && !md_issued_q) begin
                    md_start = 1'b1;
                    StallF   = 1'b1;
                    StallD   = 1'b1;
                    StallE   = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_MD_WAIT;
                end else if (load_use) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                if (md_done) begin
                    state_d = ST_RUN;
                end else if (cnt_q == CNT_LAST) begin
                    // Abort: release the pipeline and drop the md instruction.
                    err_d   = 1'b1;
                    FlushE  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (md_start) begin
            md_issued_d = 1'b1;
        end else if (!md_req_E || FlushE) begin
            md_issued_d = 1'b0;
        end else begin
            md_issued_d = md_issued_q;
        end

        // Outputs are quiet while reset is held, independent of the inputs.
        if (!reset_n) begin
            md_start = 1'b0;
            StallF   = 1'b0;
            StallD   = 1'b0;
            StallE   = 1'b0;
            FlushD   = 1'b0;
            FlushE   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            md_issued_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            md_issued_q <= md_issued_d;
            err_q       <= err_d;
        end
    end

    assign md_timeout_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (StallD && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (FlushE && (flush_count_q != 32'hFFFF_FFFF)) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl (MD_TIMEOUT = 8). Directed
// scenarios plus a randomized run checked against a rule-level model.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic       MemRead_E, RegWrite_E, RegWrite_M, RegWrite_W;
    logic       branch_taken_E, md_req_E, md_done;
    logic       md_start, StallF, StallD, StallE, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       md_timeout_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rs1_D          (rs1_D),
        .rs2_D          (rs2_D),
        .rs1_E          (rs1_E),
        .rs2_E          (rs2_E),
        .rd_E           (rd_E),
        .MemRead_E      (MemRead_E),
        .RegWrite_E     (RegWrite_E),
        .rd_M           (rd_M),
        .RegWrite_M     (RegWrite_M),
        .rd_W           (rd_W),
        .RegWrite_W     (RegWrite_W),
        .branch_taken_E (branch_taken_E),
        .md_req_E       (md_req_E),
        .md_done        (md_done),
        .md_start       (md_start),
        .StallF         (StallF),
        .StallD         (StallD),
        .StallE         (StallE),
        .FlushD         (FlushD),
        .FlushE         (FlushE),
        .ForwardAE      (ForwardAE),
        .ForwardBE      (ForwardBE),
        .md_timeout_err (md_timeout_err)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
`endif
    );

    // {md_start, StallF, StallD, StallE, FlushD, FlushE}
    function automatic logic [5:0] ctrl();
        return {md_start, StallF, StallD, StallE, FlushD, FlushE};
    endfunction

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input logic [4:0] rdm,
                                           input logic wm, input logic [4:0] rdw, input logic ww);
        if (wm && rdm != 0 && rdm == rs) return 2'b10;
        if (ww && rdw != 0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic set_idle();
        rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
        MemRead_E = 0; RegWrite_E = 0; RegWrite_M = 0; RegWrite_W = 0;
        branch_taken_E = 0; md_req_E = 0; md_done = 0;
    endtask

    // Advance one full cycle; returns just after the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        set_idle();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        md_req_E = 1; MemRead_E = 1; rd_E = 3; rs1_D = 3; branch_taken_E = 0;
        #1;
        n_checks++;
        if (ctrl() !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000000", ctrl());
        end
        n_checks++;
        if (md_timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b want 0", md_timeout_err);
        end
        tick();
        #1;
        n_checks++;
        if (ctrl() !== 6'b0) begin
            n_fail++; $display("FAIL reset_hold_ctrl: got %b want 000000", ctrl());
        end
        @(negedge clk);
        set_idle();
        md_req_E = 1;
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (ctrl() !== 6'b111100) begin
            n_fail++; $display("FAIL reset_first_edge_launch: got %b want 111100", ctrl());
        end
        tick();
        md_req_E = 0;
        #1;
        n_checks++;
        if (ctrl() !== 6'b011100) begin
            n_fail++; $display("FAIL reset_then_wait: got %b want 011100", ctrl());
        end
        do_reset();
    endtask

    task automatic test_forwarding();
        set_idle();
        rs1_E = 5; rd_M = 5; RegWrite_M = 1; rd_W = 5; RegWrite_W = 1;
        #1;
        n_checks++;
        if (ForwardAE !== 2'b10) begin
            n_fail++; $display("FAIL fwd_mem_beats_wb: got %b want 10", ForwardAE);
        end
        rd_M = 0;
        #1;
        n_checks++;
        if (ForwardAE !== 2'b01) begin
            n_fail++; $display("FAIL fwd_wb_rdm_zero: got %b want 01", ForwardAE);
        end
        rs2_E = 5; RegWrite_W = 0;
        #1;
        n_checks++;
        if (ForwardBE !== 2'b00) begin
            n_fail++; $display("FAIL fwd_b_no_write: got %b want 00", ForwardBE);
        end
        for (int i = 0; i < 40; i++) begin
            rs1_E = 5'($urandom_range(0, 3)); rs2_E = 5'($urandom_range(0, 3));
            rd_M = 5'($urandom_range(0, 3));  rd_W = 5'($urandom_range(0, 3));
            RegWrite_M = 1'($urandom); RegWrite_W = 1'($urandom);
            #1;
            n_checks++;
            if ({ForwardAE, ForwardBE} !==
                {fwd_ref(rs1_E, rd_M, RegWrite_M, rd_W, RegWrite_W),
                 fwd_ref(rs2_E, rd_M, RegWrite_M, rd_W, RegWrite_W)}) begin
                n_fail++;
                $display("FAIL fwd_random[%0d]: got A=%b B=%b want A=%b B=%b", i, ForwardAE, ForwardBE,
                         fwd_ref(rs1_E, rd_M, RegWrite_M, rd_W, RegWrite_W),
                         fwd_ref(rs2_E, rd_M, RegWrite_M, rd_W, RegWrite_W));
            end
        end
        set_idle();
        tick();
    endtask

    task automatic test_load_use();
        set_idle();
        MemRead_E = 1; rd_E = 7; rs2_D = 7;
        #1;
        n_checks++;
        if (ctrl() !== 6'b011001) begin
            n_fail++; $display("FAIL load_use_stall: got %b want 011001", ctrl());
        end
        tick();
        rd_E = 0;   // bubble now in EX
        #1;
        n_checks++;
        if (ctrl() !== 6'b000000) begin
            n_fail++; $display("FAIL load_use_one_cycle: got %b want 000000", ctrl());
        end
        rd_E = 7; branch_taken_E = 1;
        #1;
        n_checks++;
        if (ctrl() !== 6'b000011) begin
            n_fail++; $display("FAIL branch_over_load_use: got %b want 000011", ctrl());
        end
        tick();
        set_idle();
        tick();
    endtask

    task automatic test_muldiv();
        int starts = 0;
        int stalls = 0;
        logic [5:0] after_done;
        set_idle();
        md_req_E = 1;
        after_done = 6'bx;
        for (int k = 0; k < 10; k++) begin
            md_done = (k == 6);
            #1;
            if (md_start) starts++;
            if (StallE) stalls++;
            if (k == 7) after_done = ctrl();
            tick();
        end
        n_checks++;
        if (starts !== 1) begin
            n_fail++; $display("FAIL md_start_pulses: got %0d want 1", starts);
        end
        n_checks++;
        if (stalls !== 6) begin
            n_fail++; $display("FAIL md_stallE_cycles: got %0d want 6", stalls);
        end
        n_checks++;
        if (after_done !== 6'b0) begin
            n_fail++; $display("FAIL md_no_relaunch: got %b want 000000", after_done);
        end
        set_idle();
        tick();
    endtask

    task automatic test_reset_mid_wait();
        set_idle();
        md_req_E = 1;
        tick();                       // launch cycle
        tick();                       // wait cycle 1
        tick();                       // wait cycle 2
        #1;                           // wait cycle 3
        n_checks++;
        if (StallE !== 1'b1) begin
            n_fail++; $display("FAIL mid_wait_stalled: got %b want 1", StallE);
        end
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({ctrl(), md_timeout_err} !== 7'b0) begin
            n_fail++; $display("FAIL reset_mid_wait: got %b want 0000000", {ctrl(), md_timeout_err});
        end
        @(negedge clk);
        set_idle();
        reset_n = 1'b1;
        tick();
        #1;
        n_checks++;
        if ({ctrl(), md_timeout_err} !== 7'b0) begin
            n_fail++; $display("FAIL after_reset_mid_wait: got %b want 0000000", {ctrl(), md_timeout_err});
        end
        tick();
    endtask

    task automatic test_timeout();
        int stalled = 0;
        int tk = -1;
        logic err_before = 1'bx;
        logic [5:0] at_to = 6'bx;
        set_idle();
        md_req_E = 1;
        for (int k = 0; k < 20; k++) begin
            if (k == 1) md_req_E = 0;
            #1;
            if (FlushE) begin
                tk = k; err_before = md_timeout_err; at_to = ctrl();
                tick();
                break;
            end
            if (StallE) stalled++;
            tick();
        end
        n_checks++;
        if (tk !== TO) begin
            n_fail++; $display("FAIL timeout_cycle: got %0d want %0d", tk, TO);
        end
        n_checks++;
        if (stalled !== TO) begin
            n_fail++; $display("FAIL timeout_stalled: got %0d want %0d", stalled, TO);
        end
        n_checks++;
        if ({at_to, err_before} !== 7'b0000010) begin
            n_fail++; $display("FAIL timeout_release: got %b want 0000010", {at_to, err_before});
        end
        #1;
        n_checks++;
        if ({ctrl(), md_timeout_err} !== 7'b0000001) begin
            n_fail++; $display("FAIL timeout_err_set: got %b want 0000001", {ctrl(), md_timeout_err});
        end
        repeat (5) tick();
        #1;
        n_checks++;
        if (md_timeout_err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_err_sticky: got %b want 1", md_timeout_err);
        end
    endtask

    task automatic test_random();
        logic m_busy, m_issued, m_err, n_busy, n_issued, n_err;
        int m_waited, n_waited;
        logic [5:0] e_ctrl;
        logic lu;
        do_reset();
        m_busy = 0; m_issued = 0; m_err = 0; m_waited = 0;
        for (int i = 0; i < 400; i++) begin
            rs1_D = 5'($urandom_range(0, 3)); rs2_D = 5'($urandom_range(0, 3));
            rs1_E = 5'($urandom_range(0, 3)); rs2_E = 5'($urandom_range(0, 3));
            rd_E  = 5'($urandom_range(0, 3)); rd_M  = 5'($urandom_range(0, 3));
            rd_W  = 5'($urandom_range(0, 3));
            MemRead_E = ($urandom_range(0, 2) == 0); RegWrite_E = 1'($urandom);
            RegWrite_M = 1'($urandom); RegWrite_W = 1'($urandom);
            branch_taken_E = ($urandom_range(0, 7) == 0);
            md_req_E = ($urandom_range(0, 2) == 0);
            md_done  = ($urandom_range(0, 9) == 0);
            lu = MemRead_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);

            e_ctrl = 6'b0;
            n_busy = m_busy; n_waited = m_waited; n_err = m_err;
            if (!m_busy) begin
                if (branch_taken_E)                 e_ctrl = 6'b000011;
                else if (md_req_E && !m_issued) begin
                    e_ctrl = 6'b111100; n_busy = 1; n_waited = 0;
                end else if (lu)                    e_ctrl = 6'b011001;
            end else begin
                if (md_done)                        n_busy = 0;
                else if (m_waited == TO - 1) begin
                    e_ctrl = 6'b000001; n_err = 1; n_busy = 0;
                end else begin
                    e_ctrl = 6'b011100; n_waited = m_waited + 1;
                end
            end
            if (e_ctrl[5])                        n_issued = 1;
            else if (!md_req_E || e_ctrl[0])      n_issued = 0;
            else                                  n_issued = m_issued;

            #1;
            n_checks++;
            if ({ctrl(), md_timeout_err, ForwardAE, ForwardBE} !==
                {e_ctrl, m_err, fwd_ref(rs1_E, rd_M, RegWrite_M, rd_W, RegWrite_W),
                 fwd_ref(rs2_E, rd_M, RegWrite_M, rd_W, RegWrite_W)}) begin
                n_fail++;
                $display("FAIL random[%0d]: got ctrl=%b err=%b fa=%b fb=%b want ctrl=%b err=%b fa=%b fb=%b",
                         i, ctrl(), md_timeout_err, ForwardAE, ForwardBE, e_ctrl, m_err,
                         fwd_ref(rs1_E, rd_M, RegWrite_M, rd_W, RegWrite_W),
                         fwd_ref(rs2_E, rd_M, RegWrite_M, rd_W, RegWrite_W));
            end
            tick();
            m_busy = n_busy; m_waited = n_waited; m_err = n_err; m_issued = n_issued;
        end
        set_idle();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_counters();
        do_reset();
        #1;
        n_checks++;
        if ({stall_cycles, flush_count} !== 64'd0) begin
            n_fail++; $display("FAIL perf_reset: got %0d/%0d want 0/0", stall_cycles, flush_count);
        end
        for (int j = 0; j < 3; j++) begin
            MemRead_E = 1; rd_E = 4; rs1_D = 4;
            tick();
            set_idle();
            tick();
        end
        md_req_E = 1;
        tick();
        md_req_E = 0;
        repeat (3) tick();
        md_done = 1;
        tick();
        set_idle();
        tick();
        #1;
        n_checks++;
        if ({stall_cycles, flush_count} !== {32'd7, 32'd3}) begin
            n_fail++; $display("FAIL perf_counts: got %0d/%0d want 7/3", stall_cycles, flush_count);
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        set_idle();
        test_reset();
        test_forwarding();
        test_load_use();
        test_muldiv();
        test_reset_mid_wait();
        test_timeout();
        test_random();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
